// File: rtl/mvmpu_sched.sv
// Round-robin job scheduler sharing one MVMPU engine between NREQ requesters.
// Optional watchdog abort is built when MVS_TIMEOUT_EN is defined.
module mvmpu_sched #(
  parameter int NREQ    = 4,
  parameter int VAW     = 16,
  parameter int MAW     = 16,
  parameter int TMO_CYC = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*16-1:0]    desc_n,
  input  logic [NREQ*16-1:0]    desc_m,
  input  logic [NREQ*VAW-1:0]   desc_rdsv,
  input  logic [NREQ*VAW-1:0]   desc_wrsv,
  input  logic [NREQ*MAW-1:0]   desc_rdsm,
  output logic [NREQ-1:0]       ack,
  output logic [NREQ-1:0]       done,
  output logic                  err,
  output logic                  busy,
  output logic [2:0]            cur_id,
  output logic                  mv_start,
  input  logic                  mv_ready,
  output logic [15:0]           mv_matrix_n,
  output logic [15:0]           mv_matrix_m,
  output logic [VAW-1:0]        mv_addr_rdsv,
  output logic [VAW-1:0]        mv_addr_wrsv,
  output logic [MAW-1:0]        mv_addr_rdsm
);

  if (NREQ < 2 || NREQ > 8 || TMO_CYC < 1 || TMO_CYC > 65535) begin : g_bad_cfg
    $error("mvmpu_sched: parameter out of range");
  end

  typedef enum logic [2:0] {IDLE, START, WAITACC, RUN, FIN} state_t;

  localparam logic [3:0] NREQ4 = 4'(NREQ);
  localparam logic [2:0] LAST  = 3'(NREQ - 1);

  state_t     state;
  logic [2:0] ptr;
  logic       zdim;

  // Descriptor fields unpacked into fixed 8-entry tables so a 3-bit id indexes them exactly.
  logic [7:0]     req8;
  logic [15:0]    n_arr    [8];
  logic [15:0]    m_arr    [8];
  logic [VAW-1:0] rdsv_arr [8];
  logic [VAW-1:0] wrsv_arr [8];
  logic [MAW-1:0] rdsm_arr [8];

  for (genvar g = 0; g < 8; g++) begin : g_desc
    if (g < NREQ) begin : g_on
      assign req8[g]     = req[g];
      assign n_arr[g]    = desc_n[16*g +: 16];
      assign m_arr[g]    = desc_m[16*g +: 16];
      assign rdsv_arr[g] = desc_rdsv[VAW*g +: VAW];
      assign wrsv_arr[g] = desc_wrsv[VAW*g +: VAW];
      assign rdsm_arr[g] = desc_rdsm[MAW*g +: MAW];
    end else begin : g_off
      assign req8[g]     = 1'b0;
      assign n_arr[g]    = '0;
      assign m_arr[g]    = '0;
      assign rdsv_arr[g] = '0;
      assign wrsv_arr[g] = '0;
      assign rdsm_arr[g] = '0;
    end
  end

  logic       gnt_ok;
  logic [2:0] gnt_id;
  logic [3:0] scan;

  always_comb begin
    gnt_ok = 1'b0;
    gnt_id = '0;
    scan   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan = {1'b0, ptr} + k[3:0];
      if (scan >= NREQ4) scan = scan - NREQ4;
      if (!gnt_ok && req8[scan[2:0]]) begin
        gnt_ok = 1'b1;
        gnt_id = scan[2:0];
      end
    end
  end

  logic gnt_zero;
  assign gnt_zero = (n_arr[gnt_id] == 16'd0) || (m_arr[gnt_id] == 16'd0);

  function automatic logic [NREQ-1:0] onehot(input logic [2:0] id);
    onehot = NREQ'(1) << id;
  endfunction

  assign busy = (state != IDLE);

`ifdef MVS_TIMEOUT_EN
  localparam logic [15:0] TMO_LIM = 16'(TMO_CYC - 1);
  logic [15:0] wdog;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      zdim         <= 1'b0;
      ack          <= '0;
      done         <= '0;
      err          <= 1'b0;
      cur_id       <= '0;
      mv_start     <= 1'b0;
      mv_matrix_n  <= '0;
      mv_matrix_m  <= '0;
      mv_addr_rdsv <= '0;
      mv_addr_wrsv <= '0;
      mv_addr_rdsm <= '0;
`ifdef MVS_TIMEOUT_EN
      wdog         <= '0;
`endif
    end else begin
      ack      <= '0;
      done     <= '0;
      err      <= 1'b0;
      mv_start <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_ok && mv_ready) begin
            ack          <= onehot(gnt_id);
            cur_id       <= gnt_id;
            mv_matrix_n  <= n_arr[gnt_id];
            mv_matrix_m  <= m_arr[gnt_id];
            mv_addr_rdsv <= rdsv_arr[gnt_id];
            mv_addr_wrsv <= wrsv_arr[gnt_id];
            mv_addr_rdsm <= rdsm_arr[gnt_id];
            if (gnt_zero) begin
              zdim  <= 1'b1;
              state <= FIN;
            end else begin
              state <= START;
            end
          end
        end
        START: begin
          mv_start <= 1'b1;
`ifdef MVS_TIMEOUT_EN
          wdog     <= '0;
`endif
          state    <= WAITACC;
        end
        WAITACC: begin
`ifdef MVS_TIMEOUT_EN
          wdog <= wdog + 16'd1;
`endif
          if (!mv_ready) begin
            state <= RUN;
`ifdef MVS_TIMEOUT_EN
          end else if (wdog == TMO_LIM) begin
            done  <= onehot(cur_id);
            err   <= 1'b1;
            state <= FIN;
`endif
          end
        end
        RUN: begin
`ifdef MVS_TIMEOUT_EN
          wdog <= wdog + 16'd1;
`endif
          if (mv_ready) begin
            done  <= onehot(cur_id);
            state <= FIN;
`ifdef MVS_TIMEOUT_EN
          end else if (wdog == TMO_LIM) begin
            done  <= onehot(cur_id);
            err   <= 1'b1;
            state <= FIN;
`endif
          end
        end
        FIN: begin
          // Rejected jobs enter FIN together with ack, so their done goes out on FIN exit.
          if (zdim) begin
            done <= onehot(cur_id);
            err  <= 1'b1;
            zdim <= 1'b0;
          end
          ptr   <= (cur_id == LAST) ? 3'd0 : cur_id + 3'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mvmpu_sched.sv
// Directed self-checking bench for mvmpu_sched (default build, NREQ=4).
module tb_mvmpu_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [63:0] desc_n = '0, desc_m = '0;
  logic [63:0] desc_rdsv = '0, desc_wrsv = '0, desc_rdsm = '0;
  logic        mv_ready = 1'b1;
  logic [3:0]  ack, done;
  logic        err, busy, mv_start;
  logic [2:0]  cur_id;
  logic [15:0] mv_matrix_n, mv_matrix_m, mv_addr_rdsv, mv_addr_wrsv, mv_addr_rdsm;

  int tests = 0;
  int fails = 0;

  mvmpu_sched #(.NREQ(4), .VAW(16), .MAW(16), .TMO_CYC(65535)) dut (
    .clk(clk), .rst(rst), .req(req),
    .desc_n(desc_n), .desc_m(desc_m),
    .desc_rdsv(desc_rdsv), .desc_wrsv(desc_wrsv), .desc_rdsm(desc_rdsm),
    .ack(ack), .done(done), .err(err), .busy(busy), .cur_id(cur_id),
    .mv_start(mv_start), .mv_ready(mv_ready),
    .mv_matrix_n(mv_matrix_n), .mv_matrix_m(mv_matrix_m),
    .mv_addr_rdsv(mv_addr_rdsv), .mv_addr_wrsv(mv_addr_wrsv),
    .mv_addr_rdsm(mv_addr_rdsm)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serves one granted job: engine stays busy for run_cyc cycles after accepting start.
  task automatic serve(input logic [3:0] exp_ack, input logic [15:0] exp_n, input int run_cyc);
    for (int k = 0; k < 10 && ack == 4'b0; k++) tick();
    chk("serve_ack", 32'(ack), 32'(exp_ack));
    tick();
    chk("serve_start", 32'(mv_start), 32'd1);
    chk("serve_n", 32'(mv_matrix_n), 32'(exp_n));
    mv_ready = 1'b0;
    for (int k = 0; k < run_cyc; k++) tick();
    chk("serve_nodone", 32'(done), 32'd0);
    mv_ready = 1'b1;
    tick();
    chk("serve_done", 32'(done), 32'(exp_ack));
    chk("serve_err", 32'(err), 32'd0);
    tick();
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(mv_start), 32'd0);
    chk("rst_curid", 32'(cur_id), 32'd0);
    chk("rst_n", 32'(mv_matrix_n), 32'd0);
    rst = 1'b0;
    tick();

    // Single job on requester 2; other slots carry decoy descriptors
    desc_n    = {16'd9, 16'd4, 16'd9, 16'd9};
    desc_m    = {16'd7, 16'd8, 16'd7, 16'd7};
    desc_rdsv = {16'hAAAA, 16'h0010, 16'hAAAA, 16'hAAAA};
    desc_wrsv = {16'hBBBB, 16'h0020, 16'hBBBB, 16'hBBBB};
    desc_rdsm = {16'hCCCC, 16'h0100, 16'hCCCC, 16'hCCCC};
    req = 4'b0100;
    tick();
    chk("j1_ack", 32'(ack), 32'h4);
    chk("j1_curid", 32'(cur_id), 32'd2);
    chk("j1_busy", 32'(busy), 32'd1);
    chk("j1_start_early", 32'(mv_start), 32'd0);
    chk("j1_n", 32'(mv_matrix_n), 32'd4);
    chk("j1_m", 32'(mv_matrix_m), 32'd8);
    chk("j1_rdsv", 32'(mv_addr_rdsv), 32'h10);
    chk("j1_wrsv", 32'(mv_addr_wrsv), 32'h20);
    chk("j1_rdsm", 32'(mv_addr_rdsm), 32'h100);
    req = 4'b0000;
    desc_n[47:32] = 16'h0077;
    tick();
    chk("j1_start", 32'(mv_start), 32'd1);
    chk("j1_ack_off", 32'(ack), 32'd0);
    chk("j1_n_hold", 32'(mv_matrix_n), 32'd4);
    mv_ready = 1'b0;
    tick();
    chk("j1_start_off", 32'(mv_start), 32'd0);
    for (int k = 0; k < 19; k++) tick();
    chk("j1_nodone", 32'(done), 32'd0);
    chk("j1_busy_run", 32'(busy), 32'd1);
    mv_ready = 1'b1;
    tick();
    chk("j1_done", 32'(done), 32'h4);
    chk("j1_err", 32'(err), 32'd0);
    chk("j1_rdsm_hold", 32'(mv_addr_rdsm), 32'h100);
    tick();
    chk("j1_done_off", 32'(done), 32'd0);
    chk("j1_idle", 32'(busy), 32'd0);

    // Zero dimension on requester 1: rejected, no start
    desc_n[31:16] = 16'd0;
    desc_m[31:16] = 16'd5;
    req = 4'b0010;
    tick();
    chk("z_ack", 32'(ack), 32'h2);
    chk("z_nostart0", 32'(mv_start), 32'd0);
    req = 4'b0000;
    tick();
    chk("z_done", 32'(done), 32'h2);
    chk("z_err", 32'(err), 32'd1);
    chk("z_nostart1", 32'(mv_start), 32'd0);
    tick();
    chk("z_done_off", 32'(done), 32'd0);
    chk("z_nostart2", 32'(mv_start), 32'd0);
    chk("z_idle", 32'(busy), 32'd0);

    // Engine busy holds off the grant
    desc_n = {16'd4, 16'd3, 16'd2, 16'd1};
    desc_m = {16'd2, 16'd2, 16'd2, 16'd2};
    mv_ready = 1'b0;
    req = 4'b0001;
    tick();
    chk("eb_noack0", 32'(ack), 32'd0);
    tick();
    chk("eb_noack1", 32'(ack), 32'd0);
    chk("eb_idle", 32'(busy), 32'd0);
    mv_ready = 1'b1;
    tick();
    chk("eb_ack", 32'(ack), 32'h1);
    serve(4'b0001, 16'd1, 2);
    req = 4'b0000;

    // Mid-job reset on requester 3
    req = 4'b1000;
    tick();
    chk("mr_ack", 32'(ack), 32'h8);
    req = 4'b0000;
    tick();
    chk("mr_start", 32'(mv_start), 32'd1);
    mv_ready = 1'b0;
    tick();
    tick();
    chk("mr_busy_run", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_start_off", 32'(mv_start), 32'd0);
    chk("mr_n_clr", 32'(mv_matrix_n), 32'd0);
    chk("mr_curid", 32'(cur_id), 32'd0);
    mv_ready = 1'b1;
    tick();
    chk("mr_nodone", 32'(done), 32'd0);
    rst = 1'b0;
    tick();
    chk("mr_nodone2", 32'(done), 32'd0);
    // Pointer must be back at 0: requester 0 wins over 3
    req = 4'b1001;
    serve(4'b0001, 16'd1, 2);
    req = 4'b1000;
    serve(4'b1000, 16'd4, 2);
    req = 4'b0000;

    // Contention: all four held, round-robin from 0
    req = 4'b1111;
    serve(4'b0001, 16'd1, 3);
    serve(4'b0010, 16'd2, 3);
    serve(4'b0100, 16'd3, 3);
    serve(4'b1000, 16'd4, 3);
    serve(4'b0001, 16'd1, 3);
    req = 4'b0000;
    tick();
    tick();
    chk("rr_idle", 32'(busy), 32'd0);
    chk("rr_noack", 32'(ack), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
